// File: rtl/pcie_cpl_gen.sv
// pcie_cpl_gen: completer-side responder.
//   Request side : req_valid/req_ready handshake with decoded TLP header fields
//                  (fmt, type, tc, length, requestID, addr); cfg_completID is
//                  sampled when a request is accepted.
//   Memory side  : mem_rd_en/mem_addr strobe, mem_rdata returned one cycle later.
//   Completion   : cpl_valid/cpl_ready handshake with completion header fields and
//                  a 1024-bit data bus (DW k in bits [32k+31:32k]).
// MRd requests are read from memory in chunks of up to MAX_DW DWs, one completion
// per chunk. MWr requests are dropped. Anything else gets a UR completion.

// One data lane of the completion payload: cleared at chunk start, loaded by
// the read that targets this lane.
module pcie_cpl_lane (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   q <= '0;
        else if (clr) q <= '0;
        else if (wr)  q <= wdata;
    end
endmodule

module pcie_cpl_gen #(
    parameter int MAX_DW = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // request header
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_fmt,
    input  logic [4:0]            req_type,
    input  logic [2:0]            req_tc,
    input  logic [8:0]            req_length,
    input  logic [15:0]           req_requestID,
    input  logic [31:0]           req_addr,
    input  logic [15:0]           cfg_completID,
    // local memory
    output logic                  mem_rd_en,
    output logic [31:0]           mem_addr,
    input  logic [31:0]           mem_rdata,
    // completion
    output logic                  cpl_valid,
    input  logic                  cpl_ready,
    output logic [2:0]            cpl_fmt,
    output logic [4:0]            cpl_type,
    output logic [2:0]            cpl_tc,
    output logic [8:0]            cpl_length,
    output logic [2:0]            cpl_status,
    output logic [11:0]           cpl_byte_count,
    output logic [6:0]            cpl_lower_addr,
    output logic [15:0]           cpl_requestID,
    output logic [15:0]           cpl_completID,
    output logic                  cpl_last,
    output logic [32*MAX_DW-1:0]  cpl_data
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, SEND} state_t;

    state_t      state, state_nxt;
    logic [8:0]  rem;
    logic [29:0] cur_addr;      // DW address of the current chunk
    logic [2:0]  tc;
    logic [15:0] rid, cid;
    logic        is_ur;
    logic [5:0]  rd_cnt;
    logic        cap_vld;
    logic [5:0]  cap_idx;
    logic [MAX_DW-1:0][31:0] lane_q;

    logic       accept, is_mrd, is_mwr, cpl_hs, more, clr_data, send;
    logic [5:0] n;
    logic       unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr[1:0];

    assign accept = req_valid && req_ready;
    assign is_mrd = (req_fmt[2:1] == 2'b00) && (req_type == 5'b00000) && (req_length != 9'd0);
    assign is_mwr = (req_fmt[2:1] == 2'b01) && (req_type == 5'b00000);

    // chunk size: remaining DWs capped at one data bus worth
    assign n      = (rem > 9'(MAX_DW)) ? 6'(MAX_DW) : rem[5:0];
    assign send   = (state == SEND);
    assign cpl_hs = send && cpl_ready;
    assign more   = !is_ur && (rem > {3'b000, n});
    // payload is cleared whenever a new chunk begins
    assign clr_data = (state == IDLE && accept) || (cpl_hs && more);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (accept) begin
                       if (is_mrd)       state_nxt = FETCH;
                       else if (!is_mwr) state_nxt = SEND;
                   end
            FETCH: if (rd_cnt == n - 6'd1) state_nxt = DRAIN;
            DRAIN: state_nxt = SEND;
            SEND:  if (cpl_ready) state_nxt = more ? FETCH : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            cur_addr <= '0;
            tc       <= '0;
            rid      <= '0;
            cid      <= '0;
            is_ur    <= 1'b0;
            rd_cnt   <= '0;
            cap_vld  <= 1'b0;
            cap_idx  <= '0;
        end else begin
            if (state == IDLE && accept) begin
                tc       <= req_tc;
                rid      <= req_requestID;
                cid      <= cfg_completID;
                cur_addr <= req_addr[31:2];
                rem      <= req_length;
                is_ur    <= !is_mrd;
            end else if (cpl_hs && more) begin
                cur_addr <= cur_addr + 30'(n);
                rem      <= rem - 9'(n);
            end
            if (state == FETCH && rd_cnt != n - 6'd1) rd_cnt <= rd_cnt + 6'd1;
            else                                      rd_cnt <= '0;
            // read data lands one cycle after the strobe; remember its lane
            cap_vld <= mem_rd_en;
            cap_idx <= rd_cnt;
        end
    end

    for (genvar g = 0; g < MAX_DW; g++) begin : g_lane
        pcie_cpl_lane u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr_data),
            .wr    (cap_vld && (cap_idx == 6'(g))),
            .wdata (mem_rdata),
            .q     (lane_q[g])
        );
    end

    assign req_ready = (state == IDLE);
    assign mem_rd_en = (state == FETCH);
    assign mem_addr  = mem_rd_en ? {cur_addr + 30'(rd_cnt), 2'b00} : 32'd0;

    // completion fields are zero outside SEND so reset/idle show a clean bus
    assign cpl_valid      = send;
    assign cpl_fmt        = (send && !is_ur) ? 3'b010 : 3'b000;
    assign cpl_type       = send ? 5'b01010 : 5'b00000;
    assign cpl_tc         = send ? tc : 3'd0;
    assign cpl_length     = (send && !is_ur) ? {3'b000, n} : 9'd0;
    assign cpl_status     = (send && is_ur) ? 3'b001 : 3'b000;
    assign cpl_byte_count = !send ? 12'd0 : (is_ur ? 12'd4 : {1'b0, rem, 2'b00});
    assign cpl_lower_addr = (send && !is_ur) ? {cur_addr[4:0], 2'b00} : 7'd0;
    assign cpl_requestID  = send ? rid : 16'd0;
    assign cpl_completID  = send ? cid : 16'd0;
    assign cpl_last       = send && (is_ur || rem == {3'b000, n});
    assign cpl_data       = (send && !is_ur) ? lane_q : '0;
endmodule

// File: tb/tb_pcie_cpl_gen.sv
module tb_pcie_cpl_gen;
    logic         clk = 0;
    logic         rst_n;
    logic         req_valid, req_ready;
    logic [2:0]   req_fmt, req_tc;
    logic [4:0]   req_type;
    logic [8:0]   req_length;
    logic [15:0]  req_requestID, cfg_completID;
    logic [31:0]  req_addr;
    logic         mem_rd_en;
    logic [31:0]  mem_addr, mem_rdata;
    logic         cpl_valid, cpl_ready;
    logic [2:0]   cpl_fmt, cpl_tc, cpl_status;
    logic [4:0]   cpl_type;
    logic [8:0]   cpl_length;
    logic [11:0]  cpl_byte_count;
    logic [6:0]   cpl_lower_addr;
    logic [15:0]  cpl_requestID, cpl_completID;
    logic         cpl_last;
    logic [1023:0] cpl_data;

    pcie_cpl_gen dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_fmt(req_fmt),
        .req_type(req_type), .req_tc(req_tc), .req_length(req_length),
        .req_requestID(req_requestID), .req_addr(req_addr),
        .cfg_completID(cfg_completID),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_fmt(cpl_fmt),
        .cpl_type(cpl_type), .cpl_tc(cpl_tc), .cpl_length(cpl_length),
        .cpl_status(cpl_status), .cpl_byte_count(cpl_byte_count),
        .cpl_lower_addr(cpl_lower_addr), .cpl_requestID(cpl_requestID),
        .cpl_completID(cpl_completID), .cpl_last(cpl_last), .cpl_data(cpl_data)
    );

    always #5 clk = ~clk;

    // memory: word at byte address A holds A; junk when not read
    always @(posedge clk) mem_rdata <= mem_rd_en ? mem_addr : 32'hDEAD_BEEF;

    typedef struct {
        logic [2:0]    fmt;
        logic [8:0]    len;
        logic [2:0]    st;
        logic [11:0]   bc;
        logic [6:0]    la;
        logic          last;
        logic [2:0]    tc;
        logic [15:0]   rid;
        logic [15:0]   cid;
        logic [1023:0] data;
    } cpl_t;

    cpl_t        cq[$];
    logic [31:0] rq[$];
    logic [31:0] rd_log[$];
    int          checks = 0;
    int          errors = 0;
    bit          busy = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected behaviour of one request: list of completions and read addresses.
    // Returns 1 if the request occupies the block (anything but a posted write).
    function automatic bit model_push(input logic [2:0] f, input logic [4:0] t,
                                      input logic [8:0] l, input logic [31:0] a0,
                                      input logic [2:0] tc, input logic [15:0] rid,
                                      input logic [15:0] cid);
        cpl_t        c;
        int          rem, n;
        logic [31:0] a;
        bit          mrd, mwr;
        mrd = (f == 3'b000 || f == 3'b001) && t == 5'd0 && l != 9'd0;
        mwr = (f == 3'b010 || f == 3'b011) && t == 5'd0;
        if (mwr) return 0;
        c.tc = tc; c.rid = rid; c.cid = cid;
        if (!mrd) begin
            c.fmt = 3'b000; c.len = 0; c.st = 3'b001; c.bc = 12'd4;
            c.la = 0; c.last = 1; c.data = '0;
            cq.push_back(c);
            return 1;
        end
        rem = int'(l);
        a   = a0 & 32'hFFFF_FFFC;
        while (rem > 0) begin
            n = (rem > 32) ? 32 : rem;
            c.fmt = 3'b010; c.len = 9'(n); c.st = 3'b000; c.bc = 12'(rem * 4);
            c.la = a[6:0]; c.last = (rem == n); c.data = '0;
            for (int k = 0; k < n; k++) begin
                c.data[32*k +: 32] = a + 32'(4 * k);
                rq.push_back(a + 32'(4 * k));
            end
            cq.push_back(c);
            a   = a + 32'(4 * n);
            rem = rem - n;
        end
        return 1;
    endfunction

    // compare process: every negative edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cq.delete(); rq.delete(); busy = 0;
            end else begin
                chk("req_ready", {63'd0, req_ready}, {63'd0, !busy});
                if (mem_rd_en) begin
                    if (rq.size() == 0) chk("unexpected_read", mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
                    else begin
                        chk("mem_addr", mem_addr, rq.pop_front());
                    end
                    rd_log.push_back(mem_addr);
                end
                if (cpl_valid) begin
                    if (cq.size() == 0) chk("unexpected_cpl", 64'd1, 64'd0);
                    else begin
                        cpl_t e;
                        e = cq[0];
                        checks++;
                        if (cpl_fmt !== e.fmt || cpl_type !== 5'b01010 || cpl_len_ok(e.len) == 0 ||
                            cpl_status !== e.st || cpl_byte_count !== e.bc || cpl_lower_addr !== e.la ||
                            cpl_last !== e.last || cpl_tc !== e.tc || cpl_requestID !== e.rid ||
                            cpl_completID !== e.cid) begin
                            errors++;
                            $display("FAIL cpl_hdr actual fmt=%0h type=%0h len=%0d st=%0h bc=%0d la=%0h last=%0b tc=%0h rid=%0h cid=%0h required fmt=%0h len=%0d st=%0h bc=%0d la=%0h last=%0b tc=%0h rid=%0h cid=%0h",
                                cpl_fmt, cpl_type, cpl_length, cpl_status, cpl_byte_count, cpl_lower_addr,
                                cpl_last, cpl_tc, cpl_requestID, cpl_completID,
                                e.fmt, e.len, e.st, e.bc, e.la, e.last, e.tc, e.rid, e.cid);
                        end else if (cpl_data !== e.data) begin
                            errors++;
                            for (int k = 0; k < 32; k++)
                                if (cpl_data[32*k +: 32] !== e.data[32*k +: 32]) begin
                                    $display("FAIL cpl_data lane %0d actual=%0h required=%0h",
                                             k, cpl_data[32*k +: 32], e.data[32*k +: 32]);
                                    break;
                                end
                        end
                        if (cpl_ready) begin
                            void'(cq.pop_front());
                            if (e.last) busy = 0;
                        end
                    end
                end
                if (req_valid && req_ready)
                    if (model_push(req_fmt, req_type, req_length, req_addr, req_tc,
                                   req_requestID, cfg_completID)) busy = 1;
            end
        end
    end

    function automatic bit cpl_len_ok(input logic [8:0] l);
        return cpl_length === l;
    endfunction

    task automatic send(input logic [2:0] f, input logic [4:0] t, input logic [8:0] l,
                        input logic [31:0] a, input logic [2:0] tc, input logic [15:0] rid);
        req_fmt = f; req_type = t; req_length = l; req_addr = a;
        req_tc = tc; req_requestID = rid; req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    // edges from now until cpl_valid is seen
    task automatic wait_valid(input string name, input int exp);
        int cnt = 0;
        while (!cpl_valid && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk(name, 64'(cnt), 64'(exp));
    endtask

    task automatic wait_idle(input string name);
        int cnt = 0;
        while (!(req_ready && !cpl_valid && cq.size() == 0 && rq.size() == 0) && cnt < 500) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk(name, 64'(cnt < 500), 64'd1);
    endtask

    initial begin
        int seen;
        rst_n = 0; req_valid = 0; req_fmt = 0; req_type = 0; req_tc = 0;
        req_length = 0; req_requestID = 0; req_addr = 0;
        cfg_completID = 16'hABCD; cpl_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpl_valid", {63'd0, cpl_valid}, 64'd0);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_mem_rd_en", {63'd0, mem_rd_en}, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_cpl_bc", cpl_byte_count, 64'd0);
        chk("rst_cpl_data", {63'd0, |cpl_data}, 64'd0);
        rst_n = 1;
        @(posedge clk); #1;

        // single MRd len 4 @0x100
        send(3'b000, 5'd0, 9'd4, 32'h100, 3'd3, 16'h1234);
        wait_valid("lat_single", 5);
        chk("single_fmt", cpl_fmt, 64'h2);
        chk("single_bc", cpl_byte_count, 64'd16);
        chk("single_lane3", cpl_data[127:96], 64'h10C);
        chk("single_lane4", cpl_data[159:128], 64'h0);
        chk("single_last", {63'd0, cpl_last}, 64'd1);
        wait_idle("idle_single");

        // split MRd len 40 @0x1000; completer ID must stay latched
        rd_log.delete();
        send(3'b001, 5'd0, 9'd40, 32'h1000, 3'd1, 16'h0042);
        cfg_completID = 16'h5555;
        wait_valid("lat_split1", 33);
        chk("split1_len", cpl_length, 64'd32);
        chk("split1_bc", cpl_byte_count, 64'd160);
        chk("split1_last", {63'd0, cpl_last}, 64'd0);
        chk("split1_cid", cpl_completID, 64'hABCD);
        @(posedge clk); #1;
        wait_valid("lat_split2", 9);
        chk("split2_len", cpl_length, 64'd8);
        chk("split2_bc", cpl_byte_count, 64'd32);
        chk("split2_lane0", cpl_data[31:0], 64'h1080);
        chk("split2_lane7", cpl_data[255:224], 64'h109C);
        chk("split2_last", {63'd0, cpl_last}, 64'd1);
        wait_idle("idle_split");
        chk("split_reads", 64'(rd_log.size()), 64'd40);

        // backpressure
        cpl_ready = 0;
        send(3'b000, 5'd0, 9'd2, 32'h208, 3'd7, 16'hBEEF);
        wait_valid("lat_bp", 3);
        chk("bp_la", cpl_lower_addr, 64'h08);
        repeat (10) begin
            @(posedge clk); #1;
            chk("bp_valid_held", {63'd0, cpl_valid}, 64'd1);
            chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
        end
        cpl_ready = 1;
        @(posedge clk); #1;
        chk("bp_handshake", {63'd0, cpl_valid}, 64'd0);
        chk("bp_ready_back", {63'd0, req_ready}, 64'd1);
        wait_idle("idle_bp");

        // posted write: silent
        send(3'b010, 5'd0, 9'd4, 32'h400, 3'd0, 16'h0001);
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (cpl_valid || !req_ready) seen++;
        end
        chk("mwr_silent", 64'(seen), 64'd0);

        // unsupported type
        send(3'b000, 5'b00100, 9'd1, 32'h0, 3'd5, 16'h0777);
        wait_valid("lat_ur", 0);
        chk("ur_status", cpl_status, 64'd1);
        chk("ur_len", cpl_length, 64'd0);
        chk("ur_bc", cpl_byte_count, 64'd4);
        wait_idle("idle_ur");

        // MRd of length 0
        send(3'b000, 5'd0, 9'd0, 32'h40, 3'd2, 16'h0888);
        wait_valid("lat_ur_len0", 0);
        chk("ur0_status", cpl_status, 64'd1);
        chk("ur0_fmt", cpl_fmt, 64'd0);
        wait_idle("idle_ur0");

        // address wrap
        rd_log.delete();
        send(3'b000, 5'd0, 9'd4, 32'hFFFF_FFF8, 3'd0, 16'h0099);
        wait_valid("lat_wrap", 5);
        chk("wrap_la", cpl_lower_addr, 64'h78);
        wait_idle("idle_wrap");
        chk("wrap_nreads", 64'(rd_log.size()), 64'd4);
        if (rd_log.size() == 4) begin
            chk("wrap_a0", rd_log[0], 64'hFFFF_FFF8);
            chk("wrap_a1", rd_log[1], 64'hFFFF_FFFC);
            chk("wrap_a2", rd_log[2], 64'h0000_0000);
            chk("wrap_a3", rd_log[3], 64'h0000_0004);
        end

        // reset during FETCH
        send(3'b000, 5'd0, 9'd20, 32'h300, 3'd1, 16'h0ABC);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_in_fetch", {63'd0, mem_rd_en}, 64'd1);
        rst_n = 0;
        #1;
        chk("mid_rst_valid", {63'd0, cpl_valid}, 64'd0);
        chk("mid_rst_ready", {63'd0, req_ready}, 64'd1);
        chk("mid_rst_rd_en", {63'd0, mem_rd_en}, 64'd0);
        chk("mid_rst_addr", mem_addr, 64'd0);
        @(posedge clk); #1;
        rst_n = 1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (cpl_valid || mem_rd_en) seen++;
        end
        chk("mid_quiet", 64'(seen), 64'd0);
        send(3'b000, 5'd0, 9'd1, 32'h44, 3'd4, 16'h0321);
        wait_valid("lat_after_rst", 2);
        chk("after_rst_lane0", cpl_data[31:0], 64'h44);
        chk("after_rst_len", cpl_length, 64'd1);
        wait_idle("idle_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pcie_cpl_gen.md
# pcie_cpl_gen

Completer-side responder for the PCIe model: accepts decoded request TLP headers from the receive path and returns completion TLPs toward the transmit path. Memory reads are serviced from a local 32-bit, 1-cycle-latency memory port. Responses longer than 32 DW are split into multiple 1024-bit completions. Posted writes are consumed silently; malformed or unsupported requests receive an Unsupported Request (UR) completion.

## Interface
- `MAX_DW`, 32: data DWs per completion; `1024/32`, fixed by the data bus width.
- `clk` in 1: clock; all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request header valid.
- `req_ready` out 1: block can accept a request.
- `req_fmt` in 3: request TLP fmt.
- `req_type` in 5: request TLP type.
- `req_tc` in 3: traffic class.
- `req_length` in 9: length in DW.
- `req_requestID` in 16: requester ID.
- `req_addr` in 32: byte address; bits [1:0] ignored.
- `cfg_completID` in 16: completer ID, sampled at request acceptance.
- `mem_rd_en` out 1: memory read strobe.
- `mem_addr` out 32: DW-aligned byte address.
- `mem_rdata` in 32: read data, valid the cycle after `mem_rd_en`.
- `cpl_valid` out 1: completion valid.
- `cpl_ready` in 1: downstream accepts the completion.
- `cpl_fmt` out 3: 3'b010 (CplD) or 3'b000 (Cpl).
- `cpl_type` out 5: always 5'b01010.
- `cpl_tc` out 3: echoes `req_tc`.
- `cpl_length` out 9: DWs in this completion (0 for Cpl).
- `cpl_status` out 3: 3'b000 SC, 3'b001 UR.
- `cpl_byte_count` out 12: bytes remaining including this completion.
- `cpl_lower_addr` out 7: start byte address [6:0] of this chunk, with [1:0] = 0.
- `cpl_requestID` out 16: echoes the requester ID.
- `cpl_completID` out 16: latched `cfg_completID`.
- `cpl_last` out 1: final completion for the request.
- `cpl_data` out 1024: DW k in bits [32k+31:32k]; unused lanes are 0.

## Operation
- **Classification at accept** (`req_valid && req_ready`):
  - MRd: fmt ∈ {000, 001}, type 00000, length ≠ 0.
  - MWr: fmt ∈ {010, 011}, type 00000. Dropped; block stays in IDLE and no completion is produced.
  - Anything else, including MRd with length 0, is UR: one Cpl with status 001, length 0, byte_count 4, `cpl_last` = 1.
- **Request latch:** tc, requestID, completID, `addr[31:2]` and remaining DW count `rem` (9 bits) are latched at accept.
- **FSM states:** IDLE, FETCH, DRAIN, SEND.
  - IDLE: `req_ready` = 1. MRd → FETCH. UR → SEND with the UR header. MWr stays in IDLE.
  - FETCH: chunk size `n = min(rem, 32)`. Issue `n` reads on consecutive cycles, `mem_addr = cur_addr + 4*i`. The read counter is 6 bits. After the nth read → DRAIN.
  - DRAIN: one cycle to capture the last `mem_rdata` → SEND.
  - SEND: hold all `cpl_*` outputs stable until `cpl_ready`. On the handshake, if `rem - n > 0` → FETCH with `cur_addr += 4n` and `rem -= n`; otherwise → IDLE.
- **Data capture:** `mem_rdata` for read i is written into lane i. `cpl_data` is cleared at the start of each chunk.
- **Header per chunk:** `cpl_byte_count = rem*4` (max 2044, fits 12 bits). `cpl_lower_addr = {cur_addr[6:2], 2'b00}`. `cpl_last = (rem == n)`.
- **Address arithmetic:** modulo 2^32; wrap past 0xFFFF_FFFC continues at 0x0000_0000.
- **One request at a time:** `req_ready` = 0 in all states except IDLE.

## Timing
- **Reset values:** state IDLE, `req_ready` 1, `mem_rd_en` 0, `mem_addr` 0, and all `cpl_*` outputs 0, including `cpl_valid`.
- **Reset mid-operation:** immediately returns to IDLE. Any in-flight completion is discarded. Nothing is emitted after release until a new request arrives.
- **MRd latency:** with acceptance at cycle 0, reads issue in cycles 1..n and the last data is captured at the end of cycle n+1. `cpl_valid` rises in cycle n+2.
- **Following chunks:** the first read issues the cycle after the `cpl_ready` handshake, so the inter-chunk gap is n+2 cycles.
- **UR latency:** `cpl_valid` rises in cycle 1.
- **Return to IDLE:** `req_ready` returns to 1 the cycle after the final completion handshake.
- **Completion handshake:** `cpl_valid` never drops without `cpl_ready`. `cpl_ready` may be held high permanently.
- **Read strobe:** `mem_rd_en` is high only in FETCH, exactly n cycles per chunk.

## Test plan
- **Single MRd:** MRd, len 4, addr 0x100, memory word at A = A. Expect CplD in cycle 6: fmt 010, len 4, byte_count 16, lower_addr 0x00, lanes 0..3 = 0x100..0x10C, lanes 4..31 = 0, `cpl_last` = 1.
- **Split MRd:** MRd, len 40, addr 0x1000. Expect two CplDs.
  - First: len 32, byte_count 160, lower_addr 0x00, `cpl_last` = 0.
  - Second: len 8, byte_count 32, lower_addr 0x00, data 0x1080..0x109C, `cpl_last` = 1.
  - Total `mem_rd_en` pulses = 40.
- **Backpressure:** `cpl_ready` held low 10 cycles during SEND. Expect all outputs stable and `req_ready` = 0; the handshake occurs on the cycle `cpl_ready` rises.
- **Posted write and UR:**
  - MWr (fmt 010) gives no `cpl_valid` and `req_ready` stays 1.
  - fmt 000, type 00100 gives a Cpl in cycle 1 with status 001, len 0, byte_count 4.
  - MRd with len 0 gives the same UR response.
- **Address wrap:** MRd, len 4, addr 0xFFFF_FFF8. Expect `mem_addr` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004; lower_addr 0x78.
- **Mid-operation reset:** `rst_n` asserted during FETCH of a len-20 MRd. Expect outputs at reset values, no completion after release, and a subsequent len-1 MRd completes normally.
